// File: rtl/ula_pkg.sv
// Shared constants for the ULA sequencing stage.
//   DW / NREG / RW : data width, register count, register index width
//   OP_ADD..OP_NOT : 3-bit opcodes as carried on in_op
//   state_t        : sequencer FSM states
package ula_pkg;

    localparam int DW   = 4;
    localparam int NREG = 4;
    localparam int RW   = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ula_regfile.sv
// NREG x DW general register file.
//   clk, rst            : clock, synchronous active-high reset (clears all)
//   we, waddr, wdata    : single write port
//   raddr_a/rdata_a     : combinational operand A read port
//   raddr_b/rdata_b     : combinational operand B read port
//   dbg_sel/dbg_data    : combinational debug read port
module ula_regfile
    import ula_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/ula_exec_ctrl.sv
// Sequencing stage in front of the combinational 4-bit ULA.
// Accepts one instruction per in_valid/in_ready handshake, latches its
// operands from the register file (or immediate), drives the ULA for one
// EXEC cycle, writes the ULA result back and offers it on out_valid/out_ready.
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready, in_op,
//   in_dst, in_srca, in_srcb,
//   in_use_imm, in_imm              : instruction input
//   alu_a, alu_b, alu_x/y/z, alu_s  : ULA operand/select drive and result
//   out_valid/out_ready,
//   out_data, out_dst               : result response
//   out_zero, out_neg               : result flags (only with ULA_FLAGS_EN)
//   dbg_sel/dbg_data                : combinational register peek
// Build option: define ULA_FLAGS_EN to add out_zero/out_neg.
module ula_exec_ctrl
    import ula_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [RW-1:0] in_dst,
    input  logic [RW-1:0] in_srca,
    input  logic [RW-1:0] in_srcb,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_x,
    output logic [2:0]    alu_y,
    output logic [2:0]    alu_z,
    input  logic [DW-1:0] alu_s,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_dst,
`ifdef ULA_FLAGS_EN
    output logic          out_zero,
    output logic          out_neg,
`endif
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data
);

    state_t        state, state_nxt;
    logic          accept;
    logic          writeback;
    logic [2:0]    op_q;
    logic [RW-1:0] dst_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    ula_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (writeback),
        .waddr    (dst_q),
        .wdata    (alu_s),
        .raddr_a  (in_srca),
        .rdata_a  (rd_a),
        .raddr_b  (in_srcb),
        .rdata_b  (rd_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        writeback = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                writeback = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand/select registers are only loaded on accept, so they double as
    // the ULA drive during EXEC and simply hold their values afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            out_data <= '0;
            out_dst  <= '0;
`ifdef ULA_FLAGS_EN
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q  <= in_op;
                dst_q <= in_dst;
                opa_q <= rd_a;
                opb_q <= in_use_imm ? in_imm : rd_b;
            end
            if (writeback) begin
                out_data <= alu_s;
                out_dst  <= dst_q;
`ifdef ULA_FLAGS_EN
                out_zero <= (alu_s == '0);
                out_neg  <= alu_s[DW-1];
`endif
            end
        end
    end

    assign alu_a = opa_q;
    assign alu_b = opb_q;
    assign alu_x = {2'b00, op_q[0]};
    assign alu_y = {2'b00, op_q[1]};
    assign alu_z = {2'b00, op_q[2]};

endmodule

// File: tb/tb_ula_exec_ctrl.sv
// Self-checking bench for ula_exec_ctrl with a behavioural ULA attached.
module tb_ula_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_dst, in_srca, in_srcb;
    logic       in_use_imm;
    logic [3:0] in_imm;
    logic [3:0] alu_a, alu_b, alu_s;
    logic [2:0] alu_x, alu_y, alu_z;
    logic       out_valid, out_ready;
    logic [3:0] out_data;
    logic [1:0] out_dst;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;
`ifdef ULA_FLAGS_EN
    logic       out_zero, out_neg;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int last_acc = 0;
    logic [3:0] ref_regs [4];

    // Observations captured by run_instr
    logic [3:0] ex_a, ex_b, r_data;
    logic [2:0] ex_x, ex_y, ex_z;
    logic       v_exec, v_resp, r_ok, r_zero, r_neg;
    logic [1:0] r_dst;

    always #5 clk = ~clk;

    function automatic logic [3:0] ula_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a << b;
            3'd3: return a >> b;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    always_comb alu_s = ula_ref({alu_z[0], alu_y[0], alu_x[0]}, alu_a, alu_b);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= cyc;
        end
    end

    ula_exec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_dst     (in_dst),
        .in_srca    (in_srca),
        .in_srcb    (in_srcb),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_z      (alu_z),
        .alu_s      (alu_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dst    (out_dst),
`ifdef ULA_FLAGS_EN
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`endif
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // Issues one instruction starting at a negedge, consumes the response
    // immediately and returns at the negedge where the block is back in IDLE.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                             input logic [1:0] sb, input logic ui, input logic [3:0] imm);
        int n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        r_ok = in_ready;
        in_valid = 1'b1; in_op = op; in_dst = dst; in_srca = sa; in_srcb = sb;
        in_use_imm = ui; in_imm = imm;
        @(negedge clk);
        in_valid = 1'b0;
        ex_a = alu_a; ex_b = alu_b; ex_x = alu_x; ex_y = alu_y; ex_z = alu_z; v_exec = out_valid;
        @(negedge clk);
        v_resp = out_valid; r_data = out_data; r_dst = out_dst;
`ifdef ULA_FLAGS_EN
        r_zero = out_zero; r_neg = out_neg;
`else
        r_zero = 1'b0; r_neg = 1'b0;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_x, alu_y, alu_z, out_data, out_dst} !== '0) begin
            failures++;
            $display("FAIL reset_regs a=%h b=%h x=%h y=%h z=%h data=%h dst=%h expected all 0",
                     alu_a, alu_b, alu_x, alu_y, alu_z, out_data, out_dst);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'd0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h expected=0", i, dbg_data);
            end
            ref_regs[i] = 4'd0;
        end
    endtask

    task automatic test_add;
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
        checks++;
        if ({ex_x[0], ex_y[0], ex_z[0]} !== 3'b000 || ex_a !== 4'd0 || ex_b !== 4'd3 || v_exec !== 1'b0) begin
            failures++;
            $display("FAIL add_exec x/y/z=%b%b%b a=%h b=%h ov=%b expected 000 0 3 0",
                     ex_x[0], ex_y[0], ex_z[0], ex_a, ex_b, v_exec);
        end
        checks++;
        if (v_resp !== 1'b1 || r_data !== 4'd3 || r_dst !== 2'd1) begin
            failures++;
            $display("FAIL add_resp valid=%b data=%h dst=%0d expected 1 3 1", v_resp, r_data, r_dst);
        end
        dbg_sel = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'd3) begin
            failures++;
            $display("FAIL add_dbg got=%h expected=3", dbg_data);
        end
        ref_regs[1] = 4'd3;
    endtask

    task automatic test_sub;
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd2);
        run_instr(3'd1, 2'd2, 2'd1, 2'd0, 1'b1, 4'd5);
        checks++;
        if (ex_x !== 3'b001 || ex_y !== 3'b000 || ex_z !== 3'b000 || r_data !== 4'hD || r_dst !== 2'd2) begin
            failures++;
            $display("FAIL sub x=%b y=%b z=%b data=%h dst=%0d expected 001 000 000 d 2",
                     ex_x, ex_y, ex_z, r_data, r_dst);
        end
`ifdef ULA_FLAGS_EN
        checks++;
        if (r_neg !== 1'b1 || r_zero !== 1'b0) begin
            failures++;
            $display("FAIL sub_flags neg=%b zero=%b expected 1 0", r_neg, r_zero);
        end
`endif
        ref_regs[1] = 4'd2;
        ref_regs[2] = 4'hD;
    endtask

    task automatic test_shl_not_xor;
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
        run_instr(3'd2, 2'd2, 2'd1, 2'd0, 1'b1, 4'd1);
        checks++;
        if (r_data !== 4'd6 || ex_y !== 3'b001) begin
            failures++;
            $display("FAIL shl data=%h y=%b expected 6 001", r_data, ex_y);
        end
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5);
        run_instr(3'd7, 2'd3, 2'd1, 2'd0, 1'b0, 4'd0);
        checks++;
        if (r_data !== 4'b1010 || r_dst !== 2'd3 || {ex_z[0], ex_y[0], ex_x[0]} !== 3'b111) begin
            failures++;
            $display("FAIL not data=%h dst=%0d zyx=%b%b%b expected a 3 111",
                     r_data, r_dst, ex_z[0], ex_y[0], ex_x[0]);
        end
        run_instr(3'd6, 2'd1, 2'd1, 2'd1, 1'b0, 4'hF);
        checks++;
        if (r_data !== 4'd0 || ex_a !== 4'd5 || ex_b !== 4'd5) begin
            failures++;
            $display("FAIL xor data=%h a=%h b=%h expected 0 5 5", r_data, ex_a, ex_b);
        end
`ifdef ULA_FLAGS_EN
        checks++;
        if (r_zero !== 1'b1 || r_neg !== 1'b0) begin
            failures++;
            $display("FAIL xor_flags zero=%b neg=%b expected 1 0", r_zero, r_neg);
        end
`endif
        ref_regs[1] = 4'd0;
        ref_regs[2] = 4'd6;
        ref_regs[3] = 4'hA;
    endtask

    task automatic test_backpressure;
        int acc0;
        in_valid = 1'b1; in_op = 3'd0; in_dst = 2'd2; in_srca = 2'd0;
        in_use_imm = 1'b1; in_imm = 4'd9;
        @(negedge clk);
        // Offer a dependent instruction while the first one is still in flight.
        in_dst = 2'd3; in_srca = 2'd2; in_imm = 4'd1;
        @(negedge clk);
        acc0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'd9 || out_dst !== 2'd2 || in_ready !== 1'b0 || acc_cnt !== acc0) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b data=%h dst=%0d in_ready=%b accepts=%0d expected 1 9 2 0 %0d",
                         i, out_valid, out_data, out_dst, in_ready, acc_cnt, acc0);
            end
            if (i < 5) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_cnt !== acc0) begin
            failures++;
            $display("FAIL bp_release in_ready=%b out_valid=%b accepts=%0d expected 1 0 %0d",
                     in_ready, out_valid, acc_cnt, acc0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || acc_cnt !== acc0 + 1) begin
            failures++;
            $display("FAIL bp_second_accept in_ready=%b accepts=%0d expected 0 %0d", in_ready, acc_cnt, acc0 + 1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_dst !== 2'd3) begin
            failures++;
            $display("FAIL bp_second_resp valid=%b data=%h dst=%0d expected 1 a 3", out_valid, out_data, out_dst);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ref_regs[2] = 4'd9;
        ref_regs[3] = 4'hA;
    endtask

    task automatic test_reset_mid;
        run_instr(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 4'd7);
        dbg_sel = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 4'd7) begin
            failures++;
            $display("FAIL rmid_pre r2=%h expected 7", dbg_data);
        end
        in_valid = 1'b1; in_op = 3'd0; in_dst = 2'd2; in_srca = 2'd2;
        in_use_imm = 1'b1; in_imm = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dbg_data !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'd0) begin
            failures++;
            $display("FAIL rmid r2=%h out_valid=%b in_ready=%b data=%h expected 0 0 1 0",
                     dbg_data, out_valid, in_ready, out_data);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dbg_data !== 4'd0) begin
            failures++;
            $display("FAIL rmid_noresp out_valid=%b r2=%h expected 0 0", out_valid, dbg_data);
        end
        for (int i = 0; i < 4; i++) ref_regs[i] = 4'd0;
    endtask

    task automatic test_random;
        logic [2:0] op;
        logic [1:0] d, sa, sb;
        logic       ui;
        logic [3:0] imm, exp;
        int         prev;
        for (int k = 0; k < 200; k++) begin
            op = 3'($urandom_range(7)); d = 2'($urandom_range(3));
            sa = 2'($urandom_range(3)); sb = 2'($urandom_range(3));
            ui = 1'($urandom_range(1)); imm = 4'($urandom_range(15));
            exp = ula_ref(op, ref_regs[sa], ui ? imm : ref_regs[sb]);
            prev = last_acc;
            run_instr(op, d, sa, sb, ui, imm);
            ref_regs[d] = exp;
            checks++;
            if (!r_ok || v_resp !== 1'b1 || r_data !== exp || r_dst !== d) begin
                failures++;
                $display("FAIL rand%0d op=%0d ok=%b valid=%b data=%h dst=%0d expected 1 1 %h %0d",
                         k, op, r_ok, v_resp, r_data, r_dst, exp, d);
            end
            if (k > 0) begin
                checks++;
                if (last_acc - prev !== 3) begin
                    failures++;
                    $display("FAIL rand_spacing%0d got=%0d expected=3", k, last_acc - prev);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== ref_regs[i]) begin
                failures++;
                $display("FAIL rand_reg%0d got=%h expected=%h", i, dbg_data, ref_regs[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_dst = '0; in_srca = '0; in_srcb = '0;
        in_use_imm = 1'b0; in_imm = '0; out_ready = 1'b0; dbg_sel = '0;
        r_zero = 1'b0; r_neg = 1'b0;
        @(negedge clk);
        test_reset;
        test_add;
        test_sub;
        test_shl_not_xor;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
